// File: rtl/match_scorer_pkg.sv
// Shared types and helpers for the match scorer: FSM states, round-result
// encoding and a counter width helper.
package match_pkg;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      SETTLE       = 3'd1,
      SCORE        = 3'd2,
      WAIT_RELEASE = 3'd3,
      MATCH_OVER   = 3'd4
   } state_e;

   // Bit 0 carries the win LED and bit 1 the lose LED
   typedef enum logic [1:0] {
      RES_TIE     = 2'b00,
      RES_WIN     = 2'b01,
      RES_LOSE    = 2'b10,
      RES_ILLEGAL = 2'b11
   } result_e;

   // Bits needed for a counter that runs 0 .. max_count-1 (at least one bit)
   function automatic int cnt_width(input int max_count);
      if (max_count <= 2) begin
         return 1;
      end else begin
         return $clog2(max_count);
      end
   endfunction

endpackage

// File: rtl/match_scorer_rise_detect.sv
// Registered rising-edge detector. The delayed copy loads a caller-chosen
// value on reset so a level already high through reset is not taken as an edge.
module rise_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_rst_val,
   input  logic i_sig,
   output logic o_rise
);

   logic r_sig_d;

   // Track last cycle's level of the input
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sig_d <= i_rst_val;
      end else begin
         r_sig_d <= i_sig;
      end
   end

   assign o_rise = i_sig & ~r_sig_d;

endmodule

// File: rtl/match_scorer.sv
// Best-of match scorer: samples each round's win/lose result a fixed delay
// after the stop press, keeps both scores, and blinks the match LED once a
// side reaches the winning count.
module match_scorer
   import match_pkg::*;
#(
   parameter int WINS_TO_MATCH = 3,
   parameter int SCORE_W       = 3,
   parameter int SETTLE_CYCLES = 2,
   parameter int BLINK_HALF    = 12_500_000
) (
   input  logic               clock,
   input  logic               reset_button,
   input  logic               stop_signal,
   input  logic               round_win,
   input  logic               round_lose,
   input  logic               new_match,
   output logic [SCORE_W-1:0] player_score,
   output logic [SCORE_W-1:0] computer_score,
   output logic               round_valid,
   output logic               round_tie,
   output logic               match_over,
   output logic               player_match_win,
   output logic               match_led,
   output logic               illegal_result
);

   localparam int SW = cnt_width(SETTLE_CYCLES);
   localparam int BW = cnt_width(BLINK_HALF);

   localparam logic [SW-1:0]      SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);
   localparam logic [SW-1:0]      SETTLE_ONE  = SW'(1);
   localparam logic [BW-1:0]      BLINK_LAST  = BW'(BLINK_HALF - 1);
   localparam logic [BW-1:0]      BLINK_ONE   = BW'(1);
   localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);
   localparam logic [SCORE_W-1:0] SCORE_WIN   = SCORE_W'(WINS_TO_MATCH);

   generate
      if ((WINS_TO_MATCH < 1) || (WINS_TO_MATCH >= (2 ** SCORE_W))) begin : g_bad_wins
         $error("match_scorer: WINS_TO_MATCH must be in 1 .. 2**SCORE_W-1");
      end
      if (SETTLE_CYCLES < 1) begin : g_bad_settle
         $error("match_scorer: SETTLE_CYCLES must be at least 1");
      end
      if (BLINK_HALF < 2) begin : g_bad_blink
         $error("match_scorer: BLINK_HALF must be at least 2");
      end
   endgenerate

   state_e             r_state;
   logic [SW-1:0]      r_settle_cnt;
   logic [BW-1:0]      r_blink_cnt;
   logic [SCORE_W-1:0] r_player;
   logic [SCORE_W-1:0] r_computer;
   logic               r_valid;
   logic               r_tie;
   logic               r_match_over;
   logic               r_pmw;
   logic               r_led;
   logic               r_illegal;

   state_e             w_state_nxt;
   logic [SW-1:0]      w_settle_nxt;
   logic [BW-1:0]      w_blink_nxt;
   logic [SCORE_W-1:0] w_player_nxt;
   logic [SCORE_W-1:0] w_computer_nxt;
   logic               w_valid_nxt;
   logic               w_tie_nxt;
   logic               w_match_over_nxt;
   logic               w_pmw_nxt;
   logic               w_led_nxt;
   logic               w_illegal_nxt;
   logic               w_rise;
   result_e            w_result;

   // Stop presses are counted only on a fresh rising edge; a stop held through
   // reset is treated as already high.
   rise_detect u_stop_rise (
      .i_clk     (clock),
      .i_reset   (reset_button),
      .i_rst_val (1'b1),
      .i_sig     (stop_signal),
      .o_rise    (w_rise)
   );

   assign w_result = result_e'({round_lose, round_win});

   // Next-state and next-value logic for the scoring FSM
   always_comb begin
      w_state_nxt      = r_state;
      w_settle_nxt     = r_settle_cnt;
      w_blink_nxt      = r_blink_cnt;
      w_player_nxt     = r_player;
      w_computer_nxt   = r_computer;
      w_valid_nxt      = 1'b0;
      w_tie_nxt        = 1'b0;
      w_match_over_nxt = r_match_over;
      w_pmw_nxt        = r_pmw;
      w_led_nxt        = r_led;
      w_illegal_nxt    = r_illegal;

      case (r_state)
         IDLE: begin
            if (w_rise) begin
               w_state_nxt  = SETTLE;
               w_settle_nxt = SETTLE_LOAD;
            end else begin
               w_state_nxt  = IDLE;
            end
         end

         SETTLE: begin
            if (r_settle_cnt == '0) begin
               w_state_nxt  = SCORE;
            end else begin
               w_settle_nxt = r_settle_cnt - SETTLE_ONE;
            end
         end

         SCORE: begin
            w_valid_nxt = 1'b1;
            case (w_result)
               RES_WIN:     w_player_nxt   = r_player + SCORE_ONE;
               RES_LOSE:    w_computer_nxt = r_computer + SCORE_ONE;
               RES_TIE:     w_tie_nxt      = 1'b1;
               RES_ILLEGAL: begin
                  w_tie_nxt     = 1'b1;
                  w_illegal_nxt = 1'b1;
               end
               default:     w_tie_nxt      = 1'b1;
            endcase
            if ((w_player_nxt == SCORE_WIN) || (w_computer_nxt == SCORE_WIN)) begin
               w_state_nxt      = MATCH_OVER;
               w_match_over_nxt = 1'b1;
               w_pmw_nxt        = (w_player_nxt == SCORE_WIN);
               w_led_nxt        = 1'b1;
               w_blink_nxt      = '0;
            end else begin
               w_state_nxt      = WAIT_RELEASE;
            end
         end

         WAIT_RELEASE: begin
            if (!stop_signal) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = WAIT_RELEASE;
            end
         end

         MATCH_OVER: begin
            if (new_match) begin
               w_player_nxt     = '0;
               w_computer_nxt   = '0;
               w_pmw_nxt        = 1'b0;
               w_led_nxt        = 1'b0;
               w_blink_nxt      = '0;
               w_match_over_nxt = 1'b0;
               w_state_nxt      = stop_signal ? WAIT_RELEASE : IDLE;
            end else if (r_blink_cnt == BLINK_LAST) begin
               w_blink_nxt      = '0;
               w_led_nxt        = ~r_led;
            end else begin
               w_blink_nxt      = r_blink_cnt + BLINK_ONE;
            end
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers; reset overrides every other input
   always_ff @(posedge clock) begin
      if (reset_button) begin
         r_state      <= IDLE;
         r_settle_cnt <= '0;
         r_blink_cnt  <= '0;
         r_player     <= '0;
         r_computer   <= '0;
         r_valid      <= 1'b0;
         r_tie        <= 1'b0;
         r_match_over <= 1'b0;
         r_pmw        <= 1'b0;
         r_led        <= 1'b0;
         r_illegal    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_blink_cnt  <= w_blink_nxt;
         r_player     <= w_player_nxt;
         r_computer   <= w_computer_nxt;
         r_valid      <= w_valid_nxt;
         r_tie        <= w_tie_nxt;
         r_match_over <= w_match_over_nxt;
         r_pmw        <= w_pmw_nxt;
         r_led        <= w_led_nxt;
         r_illegal    <= w_illegal_nxt;
      end
   end

   assign player_score     = r_player;
   assign computer_score   = r_computer;
   assign round_valid      = r_valid;
   assign round_tie        = r_tie;
   assign match_over       = r_match_over;
   assign player_match_win = r_pmw;
   assign match_led        = r_led;
   assign illegal_result   = r_illegal;

endmodule

// File: doc/match_scorer.md
Name: match_scorer

Overview:
- Downstream of the game controller: consumes its per-round win/lose LED signals and the player's stop_signal, and keeps a running best-of match score.
- Samples each round's result once per stop press, after a fixed settle delay, and counts player and computer wins.
- Declares the match over when either side reaches WINS_TO_MATCH, then blinks the match LED.
- Feeds the board score display and the match LED.

Parameters:
- WINS_TO_MATCH, 3, round wins needed to take the match (1..2**SCORE_W-1).
- SCORE_W, 3, width of each score counter.
- SETTLE_CYCLES, 2, cycles between stop rise and result sampling (>=1).
- BLINK_HALF, 12_500_000, cycles per half-period of match_led blink (>=2).

Ports:
- clock  in  1  system clock.
- reset_button  in  1  synchronous, active-high reset; already synchronized upstream.
- stop_signal  in  1  level, same signal that locks the player and computer choices.
- round_win  in  1  win_led from the game controller.
- round_lose  in  1  lose_led from the game controller.
- new_match  in  1  single-cycle pulse; clears scores after a finished match.
- player_score  out  SCORE_W  player round wins.
- computer_score  out  SCORE_W  computer round wins.
- round_valid  out  1  one-cycle pulse when a round is scored.
- round_tie  out  1  qualifies round_valid: neither win nor lose.
- match_over  out  1  level, high in MATCH_OVER.
- player_match_win  out  1  valid while match_over; 1 = player took the match.
- match_led  out  1  blinks in MATCH_OVER, 0 otherwise.
- illegal_result  out  1  sticky; set if round_win and round_lose are both sampled high.

Behaviour:
- Reset (synchronous, active-high; wins over every other input):
  - Scores reset to 0; all outputs reset to 0.
  - FSM goes to IDLE.
  - stop_d resets to 1, so a stop held through reset is not counted as a press.
- Rise detection: rise = stop_signal & ~stop_d. stop_d is registered every cycle.
- IDLE:
  - On rise at edge T, go to SETTLE with settle_cnt = SETTLE_CYCLES-1.
  - Every other input is ignored.
- SETTLE:
  - Decrement settle_cnt each cycle.
  - At count 0, go to SCORE.
  - A rise seen here is ignored.
- SCORE (exactly one cycle; inputs sampled at edge T+SETTLE_CYCLES+1):
  - win=1, lose=0: player_score +1.
  - win=0, lose=1: computer_score +1.
  - Both 0: tie; no increment, round_tie=1.
  - Both 1: treated as a tie and illegal_result is set.
  - round_valid pulses for one cycle, registered, aligned with the updated score values.
  - If the updated score equals WINS_TO_MATCH, go to MATCH_OVER and set player_match_win from which side reached it.
  - Otherwise go to WAIT_RELEASE.
- WAIT_RELEASE:
  - Stay until stop_signal = 0, then go to IDLE.
  - Exactly one round is scored per press, however long stop is held.
- MATCH_OVER:
  - Scores are frozen and stop presses are ignored.
  - match_led toggles every BLINK_HALF cycles, starting at 1 on entry.
  - new_match clears the scores, player_match_win, match_led and the blink counter, then goes to WAIT_RELEASE if stop is high, else IDLE.
- new_match outside MATCH_OVER is ignored.
- Scores never exceed WINS_TO_MATCH, so no wrap is possible.
- The parameter check must fail elaboration if WINS_TO_MATCH >= 2**SCORE_W.

Decomposition:
- Package match_pkg holds:
  - the state enum (IDLE, SETTLE, SCORE, WAIT_RELEASE, MATCH_OVER);
  - the round-result encoding (RES_TIE=2'b00, RES_WIN=2'b01, RES_LOSE=2'b10, RES_ILLEGAL=2'b11);
  - the blink counter width function.
- One sub-module, rise_detect (registered rising-edge detector with reset value input), is used for stop_signal.

Test Plan:
- Reset with stop_signal held high, then release reset while stop stays high: no round_valid, scores stay 0/0 until stop falls and rises again.
- Stop rise with win=1, lose=0 (SETTLE_CYCLES=2): round_valid exactly 3 cycles after the rise edge, player_score=1, computer_score=0, round_tie=0.
- Stop held high for 50 cycles with lose=1: exactly one round_valid, computer_score=1.
- Stop rise with win=lose=0: round_valid with round_tie=1, scores unchanged. Then a press with win=lose=1: round_tie=1 and illegal_result=1, staying set through later rounds until reset.
- Three player wins (WINS_TO_MATCH=3, BLINK_HALF=4):
  - match_over=1 and player_match_win=1 after the third round_valid.
  - match_led pattern is 1111 0000 repeating.
  - A fourth press leaves the score at 3.
- In MATCH_OVER, pulse new_match with stop low: scores 0/0, match_over=0, match_led=0, next press scored normally. Also assert reset_button during SETTLE: no round scored, state IDLE.
